// File: rtl/guess_round_ctrl.sv
// Guess-the-number round controller that drives the seven-segment display inputs.
// Optional feature macro: GUESS_HINT_EN adds the too-low/too-high HINT display state.
module guess_round_ctrl #(
  parameter int unsigned MAX_VALUE   = 9999,
  parameter int unsigned MAX_SCORE   = 7,
  parameter int unsigned WIN_CODE    = 56,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_submit,
  output logic [15:0] displayNumber,
  output logic [3:0]  displayScore,
  output logic        round_win,
  output logic [13:0] target_dbg
);

  localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [13:0] MAXV      = 14'(MAX_VALUE);
  localparam logic [13:0] WC        = 14'(WIN_CODE);
  localparam logic [13:0] WC_M1     = 14'(WIN_CODE - 1);
  localparam logic [13:0] WC_P1     = 14'(WIN_CODE + 1);
  localparam logic [3:0]  MAXS      = 4'(MAX_SCORE);
  localparam logic [15:0] DISP_WIN  = 16'(WIN_CODE);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_GUESS = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_HINT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [13:0]   guess_q, guess_d;
  logic [13:0]   target_q, target_d;
  logic [3:0]    score_q, score_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   disp_q, disp_d;
  logic          win_q, win_d;

  logic [13:0]   cand, guess_inc, guess_dec;
  logic          cand_ok, hold_done;

  // Fibonacci LFSR, taps 16,14,13,11; free-running in every state
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand      = lfsr_q[13:0];
  assign cand_ok   = (cand <= MAXV) && (cand != WC);
  assign hold_done = (hold_q == HOLD_LAST);

  // Stepping skips WIN_CODE so the player can never display "YAY" as a guess
  always_comb begin
    if (guess_q == MAXV)       guess_inc = 14'd0;
    else if (guess_q == WC_M1) guess_inc = WC_P1;
    else                       guess_inc = guess_q + 14'd1;

    if (guess_q == 14'd0)      guess_dec = MAXV;
    else if (guess_q == WC_P1) guess_dec = WC_M1;
    else                       guess_dec = guess_q - 14'd1;
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    target_d = target_q;
    score_d  = score_q;
    hold_d   = hold_q;
    win_d    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (cand_ok) begin
          target_d = cand;
          guess_d  = 14'd0;
          state_d  = S_GUESS;
        end
      end
      S_GUESS: begin
        if (btn_submit)             state_d = S_CHECK;
        else if (btn_up && !btn_down) guess_d = guess_inc;
        else if (btn_down && !btn_up) guess_d = guess_dec;
      end
      S_CHECK: begin
        hold_d = '0;
        if (guess_q == target_q) begin
          state_d = S_WIN;
          win_d   = 1'b1;
          if (score_q < MAXS) score_d = score_q + 4'd1;
        end else begin
`ifdef GUESS_HINT_EN
          state_d = S_HINT;
`else
          state_d = S_GUESS;
`endif
        end
      end
      S_WIN: begin
        if (hold_done) begin
          hold_d  = '0;
          state_d = (score_q == MAXS) ? S_DONE : S_INIT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
`ifdef GUESS_HINT_EN
      S_HINT: begin
        if (hold_done) begin
          hold_d  = '0;
          state_d = S_GUESS;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
`endif
      S_DONE: ;
      default: state_d = S_INIT;
    endcase
  end

  // Display follows the next state so it updates on the same edge as the state
  always_comb begin
    disp_d = 16'd0;
    case (state_d)
      S_GUESS, S_CHECK: disp_d = {2'b00, guess_d};
      S_WIN, S_DONE:    disp_d = DISP_WIN;
`ifdef GUESS_HINT_EN
      S_HINT:           disp_d = (guess_d < target_d) ? 16'd1 : 16'd7;
`endif
      default:          disp_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_INIT;
      lfsr_q   <= SEED;
      guess_q  <= '0;
      target_q <= '0;
      score_q  <= '0;
      hold_q   <= '0;
      disp_q   <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      guess_q  <= guess_d;
      target_q <= target_d;
      score_q  <= score_d;
      hold_q   <= hold_d;
      disp_q   <= disp_d;
      win_q    <= win_d;
    end
  end

  assign displayNumber = disp_q;
  assign displayScore  = score_q;
  assign round_win     = win_q;
  assign target_dbg    = target_q;

endmodule

// File: doc/guess_round_ctrl.md
# guess_round_ctrl

Game-round controller that sits directly upstream of the seven-segment display driver and produces its `displayNumber` and `displayScore` inputs. It picks a pseudo-random target from a free-running LFSR. The player steps a guess up or down with debounced button pulses and submits it. The block scores matches and shows a win code for a hold period. After `MAX_SCORE` wins it latches a final win display until reset.

## Interface
- `MAX_VALUE`, 9999: largest legal guess/target; must be ≤ 16383.
- `MAX_SCORE`, 7: wins needed to finish; must be ≤ 7, since the display decoder renders digits 0-7 only.
- `WIN_CODE`, 56: `displayNumber` value the display driver renders as "YAY"; never a legal guess or target.
- `HOLD_CYCLES`, 50_000_000: duration of the WIN/HINT display, in cycles; must be ≥ 1.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` input 1: system clock. One clock only.
- `reset` input 1: synchronous, active-high reset.
- `btn_up` input 1: single-cycle pulse, debounced.
- `btn_down` input 1: single-cycle pulse, debounced.
- `btn_submit` input 1: single-cycle pulse, debounced.
- `displayNumber` output 16: registered value for the display driver.
- `displayScore` output 4: registered win count, 0..`MAX_SCORE`.
- `round_win` output 1: one-cycle pulse on a correct submit.
- `target_dbg` output 14: latched target, for verification only.

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state; reset loads `SEED`.
- States: INIT, GUESS, CHECK, WIN, HINT (`HINT_EN` only), DONE.
- INIT:
  - Candidate is `lfsr[13:0]`.
  - If candidate ≤ `MAX_VALUE` and candidate ≠ `WIN_CODE`: latch the target, set guess = 0, go to GUESS.
  - Otherwise stay in INIT and retry next cycle.
- GUESS:
  - `btn_up` increments the guess. `MAX_VALUE` wraps to 0. `WIN_CODE-1` steps to `WIN_CODE+1`.
  - `btn_down` decrements the guess. 0 wraps to `MAX_VALUE`. `WIN_CODE+1` steps to `WIN_CODE-1`.
  - `btn_up` and `btn_down` in the same cycle: no change.
  - `btn_submit` goes to CHECK and takes priority; any same-cycle up/down is ignored.
- CHECK (1 cycle):
  - guess == target: go to WIN, pulse `round_win`, increment score.
  - Mismatch: go to HINT when `HINT_EN` is defined, else back to GUESS with the guess unchanged.
- WIN: hold for `HOLD_CYCLES`. Then go to DONE if score == `MAX_SCORE`, else to INIT.
- DONE: terminal state; only `reset` exits.
- Buttons are ignored in every state except GUESS.
- `displayNumber` by state:
  - INIT: 0.
  - GUESS and CHECK: {2'b00, guess}.
  - WIN and DONE: `WIN_CODE`.
  - HINT: 1 when guess < target, 7 when guess > target.
- `displayScore` saturates at `MAX_SCORE` and never wraps.

## Timing
- Reset values: state INIT, LFSR `SEED`, guess 0, target 0, score 0, hold counter 0, `displayNumber` 0, `displayScore` 0, `round_win` 0, `target_dbg` 0.
- Reset asserted in any state returns to these values on the next edge. No partial round survives a reset.
- All outputs are registered.
- A button pulse in cycle N is visible on `displayNumber` at edge N+1.
- Submit at edge N: state is CHECK at N+1.
  - Match: `round_win` = 1 and score +1 at N+2; WIN entered at N+2.
- WIN lasts exactly `HOLD_CYCLES` cycles. HINT has the same duration. The hold counter clears on entry.
- INIT latency is data-dependent: ≥ 1 cycle, with retries until the LFSR yields an in-range value.

## Configuration
- `GUESS_HINT_EN` defined:
  - The HINT state exists.
  - A mismatch shows 1 (too low) or 7 (too high) for `HOLD_CYCLES`, then returns to GUESS with the guess unchanged.
- `GUESS_HINT_EN` undefined:
  - No HINT state and no hint comparator.
  - A mismatch returns to GUESS one cycle after CHECK.
  - `displayNumber` never leaves the guess value on a miss.

## Test plan
- Reset, then 3× `btn_up` → `displayNumber` 0→1→2→3. Then `btn_down` ×4 → 2,1,0,9999 (wrap).
- From guess 55: `btn_up` → 57. Then `btn_down` → 55 (`WIN_CODE` skipped).
- Set guess = `target_dbg` and pulse submit → `round_win` pulses once two cycles later, `displayScore` 0→1, `displayNumber` = 56 for `HOLD_CYCLES`, then INIT.
- Submit `target_dbg`−1 with `GUESS_HINT_EN` → `displayNumber` = 1 for `HOLD_CYCLES`, then back to the guess.
  - Without the macro: the guess stays displayed and score is unchanged.
- Win 7 rounds with `HOLD_CYCLES`=4 → `displayScore` = 7, DONE state, `displayNumber` stuck at 56. Buttons ignored; `reset` → all outputs 0.
- Up and down pulsed in the same cycle, and submit pulsed together with up → guess unchanged; only the submit takes effect.
